// File: rtl/dbgprobe_arb.sv
// Round-robin arbiter that shares one uart_tx byte-push port among NREQ probe sources.
// Each granted sample is sent as one ASCII line: LF, CR, channel hex digit, ':', sample hex digits.
module dbgprobe_arb #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32,
  localparam int GW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  en_i,
  input  logic [NREQ-1:0]       req_i,
  input  logic [NREQ*WIDTH-1:0] data_i,
  output logic [NREQ-1:0]       ack_o,
  output logic [GW-1:0]         gnt_o,
  output logic                  busy_o,
  output logic                  push_o,
  output logic [7:0]            byte_o,
  input  logic                  full_i
);

  localparam int NNIB  = ((WIDTH - 1) >> 2) + 1;
  localparam int PW    = NNIB * 4;
  localparam int NBYTE = 4 + NNIB;
  localparam int IW    = $clog2(NBYTE + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTE - 1);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_SEND = 1'b1} state_t;

  function automatic logic [7:0] hex_char(input logic [3:0] nib);
    logic [7:0] c;
    if (nib < 4'd10) begin
      c = 8'h30 + {4'h0, nib};
    end else begin
      c = 8'h57 + {4'h0, nib};
    end
    return c;
  endfunction

  state_t           state_q, state_d;
  logic [GW-1:0]    last_q, last_d;
  logic [GW-1:0]    gnt_q, gnt_d;
  logic [PW-1:0]    shadow_q, shadow_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [NREQ-1:0]  ack_q, ack_d;
  logic             win_found_s;
  logic [GW-1:0]    win_idx_s;
  logic             push_s;
  logic [7:0]       byte_s;
  logic [PW-1:0]    nib_vec_s;

  // Round-robin search: first pending request strictly after the last grant, wrapping.
  always_comb begin
    int cand;
    cand        = 0;
    win_found_s = 1'b0;
    win_idx_s   = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = (int'(last_q) + i) % NREQ;
      if (!win_found_s && req_i[cand]) begin
        win_found_s = 1'b1;
        win_idx_s   = GW'(cand);
      end else begin
        win_idx_s   = win_idx_s;
      end
    end
  end

  // Next-state logic: grant and capture in IDLE, byte pushes with backpressure in SEND.
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    gnt_d    = gnt_q;
    shadow_d = shadow_q;
    idx_d    = idx_q;
    ack_d    = '0;
    push_s   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (en_i && win_found_s) begin
          state_d  = S_SEND;
          last_d   = win_idx_s;
          gnt_d    = win_idx_s;
          shadow_d = PW'(data_i[int'(win_idx_s)*WIDTH +: WIDTH]);
          ack_d    = {{(NREQ-1){1'b0}}, 1'b1} << win_idx_s;
          idx_d    = '0;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_SEND: begin
        if (!full_i) begin
          push_s = 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = S_IDLE;
            idx_d   = '0;
          end else begin
            idx_d   = idx_q + IW'(1);
          end
        end else begin
          push_s = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Byte selection depends only on registered state, so it holds steady under backpressure.
  always_comb begin
    int sh;
    sh = 0;
    if (idx_q >= IW'(4)) begin
      sh = 4 * (NNIB - 1 - (int'(idx_q) - 4));
    end else begin
      sh = 0;
    end
    nib_vec_s = shadow_q >> sh;
    case (idx_q)
      IW'(0):  byte_s = 8'h0A;
      IW'(1):  byte_s = 8'h0D;
      IW'(2):  byte_s = hex_char(4'(gnt_q));
      IW'(3):  byte_s = 8'h3A;
      default: byte_s = hex_char(nib_vec_s[3:0]);
    endcase
  end

  // State registers; reset aborts any line in flight and restores requester 0 priority.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q  <= S_IDLE;
      last_q   <= GW'(NREQ - 1);
      gnt_q    <= '0;
      shadow_q <= '0;
      idx_q    <= '0;
      ack_q    <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      gnt_q    <= gnt_d;
      shadow_q <= shadow_d;
      idx_q    <= idx_d;
      ack_q    <= ack_d;
    end
  end

  assign ack_o  = ack_q;
  assign gnt_o  = gnt_q;
  assign busy_o = (state_q == S_SEND);
  assign push_o = push_s;
  assign byte_o = byte_s;

endmodule

// File: tb/tb_dbgprobe_arb.sv
// Directed bench for dbgprobe_arb: expected bytes are queued when a line is requested
// and compared as the DUT pushes them; a second instance covers WIDTH=10.
module tb_dbgprobe_arb;

  logic         clk = 1'b0;
  logic         rstn, en, full;
  logic [3:0]   req, ack;
  logic [127:0] data;
  logic [1:0]   gnt;
  logic         busy, push;
  logic [7:0]   byt;

  logic [3:0]   b_req, b_ack;
  logic [39:0]  b_data;
  logic [1:0]   b_gnt;
  logic         b_busy, b_push, b_full;
  logic [7:0]   b_byt;

  int checks = 0;
  int errors = 0;
  int a_pushed = 0;
  int b_pushed = 0;
  logic [7:0] qa[$];
  logic [7:0] qb[$];

  always #5 clk = ~clk;

  dbgprobe_arb #(.NREQ(4), .WIDTH(32)) u_dut (
    .clk_i(clk), .rstn_i(rstn), .en_i(en), .req_i(req), .data_i(data),
    .ack_o(ack), .gnt_o(gnt), .busy_o(busy), .push_o(push), .byte_o(byt), .full_i(full)
  );

  dbgprobe_arb #(.NREQ(4), .WIDTH(10)) u_dut_w10 (
    .clk_i(clk), .rstn_i(rstn), .en_i(en), .req_i(b_req), .data_i(b_data),
    .ack_o(b_ack), .gnt_o(b_gnt), .busy_o(b_busy), .push_o(b_push), .byte_o(b_byt), .full_i(b_full)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input bit to_b, input int ch, input logic [31:0] d,
                          input int nnib, input int nb);
    logic [7:0] line[$];
    string hx;
    hx = "0123456789abcdef";
    line.push_back(8'h0a);
    line.push_back(8'h0d);
    line.push_back(hx.getc(ch));
    line.push_back(8'h3a);
    for (int i = nnib - 1; i >= 0; i--) line.push_back(hx.getc(int'((d >> (4 * i)) & 32'hf)));
    for (int i = 0; i < nb; i++) begin
      if (to_b) qb.push_back(line[i]);
      else      qa.push_back(line[i]);
    end
  endtask

  // Advance to the next falling edge and check every byte pushed there.
  task automatic step();
    @(negedge clk);
    if (push) begin
      a_pushed++;
      chk("a_byte_expected", qa.size() > 0, 1'b1);
      if (qa.size() > 0) chk("a_byte", byt, qa.pop_front());
    end
    if (full) chk("a_push_while_full", push, 1'b0);
    if (ack != 4'b0000) chk("a_ack_onehot", $countones(ack), 1);
    if (b_push) begin
      b_pushed++;
      chk("b_byte_expected", qb.size() > 0, 1'b1);
      if (qb.size() > 0) chk("b_byte", b_byt, qb.pop_front());
    end
  endtask

  task automatic wait_ack(input string tag, input logic [3:0] exp);
    for (int i = 0; i < 50; i++) begin
      step();
      if (ack != 4'b0000) break;
    end
    chk(tag, ack, exp);
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (busy && cyc < 200);
  endtask

  initial begin
    int cyc;
    int hold;
    logic alt;
    rstn = 1'b0; en = 1'b1; full = 1'b0; req = '0; data = '0;
    b_req = '0; b_data = '0; b_full = 1'b0;
    repeat (3) step();
    chk("rst_ack", ack, 4'b0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_gnt", gnt, 2'd0);
    chk("rst_push", push, 1'b0);
    rstn = 1'b1;
    step();

    // Single request on channel 2
    data[95:64] = 32'hDEADBEEF;
    req = 4'b0100;
    push_exp(1'b0, 2, 32'hDEADBEEF, 8, 12);
    a_pushed = 0;
    step();
    chk("t1_ack", ack, 4'b0100);
    chk("t1_gnt", gnt, 2'd2);
    chk("t1_push_first", push, 1'b1);
    req = 4'b0000;
    wait_idle(cyc);
    chk("t1_cycles", cyc, 12);
    chk("t1_bytes", a_pushed, 12);
    chk("t1_queue_empty", qa.size(), 0);

    // All requesters pending: grant order 0,1,2,3,0 from fresh reset
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    for (int k = 0; k < 4; k++) data[k*32 +: 32] = 32'h1000_0001 * (k + 1) + 32'h00AB_0000;
    for (int n = 0; n < 5; n++) push_exp(1'b0, n % 4, 32'h1000_0001 * ((n % 4) + 1) + 32'h00AB_0000, 8, 12);
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      a_pushed = 0;
      wait_ack("t2_ack", 4'b0001 << (n % 4));
      chk("t2_gnt", gnt, n % 4);
      step();
      chk("t2_ack_pulse", ack, 4'b0000);
      wait_idle(cyc);
      chk("t2_bytes", a_pushed, 12);
    end
    req = 4'b0000;
    step();
    chk("t2_no_extra_ack", ack, 4'b0000);
    chk("t2_queue_empty", qa.size(), 0);

    // Backpressure: 5 full cycles after the 6th byte, then alternating
    data[63:32] = 32'h01234567;
    push_exp(1'b0, 1, 32'h01234567, 8, 12);
    req = 4'b0010;
    a_pushed = 0;
    wait_ack("t3_ack", 4'b0010);
    req = 4'b0000;
    hold = 0;
    alt = 1'b0;
    for (int c = 0; c < 200 && busy; c++) begin
      @(posedge clk);
      #1;
      if (a_pushed >= 6) begin
        if (hold < 5) begin
          full = 1'b1;
          hold++;
        end else begin
          full = alt;
          alt = ~alt;
        end
      end else begin
        full = 1'b0;
      end
      step();
    end
    full = 1'b0;
    chk("t3_full_applied", hold, 5);
    chk("t3_bytes", a_pushed, 12);
    chk("t3_queue_empty", qa.size(), 0);

    // Enable gating
    en = 1'b0;
    data[31:0] = 32'h000000A5;
    req = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t4_no_ack", ack, 4'b0000);
      chk("t4_no_push", push, 1'b0);
    end
    push_exp(1'b0, 0, 32'h000000A5, 8, 12);
    a_pushed = 0;
    en = 1'b1;
    step();
    chk("t4_ack", ack, 4'b0001);
    en = 1'b0;
    wait_idle(cyc);
    chk("t4_bytes", a_pushed, 12);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t4_no_regrant", ack, 4'b0000);
      chk("t4_idle", busy, 1'b0);
    end
    req = 4'b0000;
    en = 1'b1;

    // Reset mid-line after 5 bytes
    data[127:96] = 32'h3333CAFE;
    data[31:0]   = 32'h0BADF00D;
    req = 4'b1001;
    push_exp(1'b0, 3, 32'h3333CAFE, 8, 5);
    a_pushed = 0;
    wait_ack("t5_ack_ch3", 4'b1000);
    for (int i = 0; i < 50 && a_pushed < 5; i++) step();
    chk("t5_partial", a_pushed, 5);
    rstn = 1'b0;
    push_exp(1'b0, 0, 32'h0BADF00D, 8, 12);
    step();
    chk("t5_push_after_rst", push, 1'b0);
    chk("t5_busy_after_rst", busy, 1'b0);
    rstn = 1'b1;
    a_pushed = 0;
    wait_ack("t5_ack_ch0", 4'b0001);
    req = 4'b0000;
    wait_idle(cyc);
    chk("t5_bytes", a_pushed, 12);
    chk("t5_queue_empty", qa.size(), 0);

    // WIDTH=10 instance: zero-extended top nibble
    b_data[19:10] = 10'h3FF;
    b_req = 4'b0010;
    push_exp(1'b1, 1, 32'h3FF, 3, 7);
    for (int i = 0; i < 50; i++) begin
      step();
      if (b_ack != 4'b0000) break;
    end
    chk("t6_ack_ch1", b_ack, 4'b0010);
    b_req = 4'b0000;
    for (int i = 0; i < 50 && b_busy; i++) step();
    b_data[9:0] = 10'h005;
    b_req = 4'b0001;
    push_exp(1'b1, 0, 32'h005, 3, 7);
    for (int i = 0; i < 50; i++) begin
      step();
      if (b_ack != 4'b0000) break;
    end
    chk("t6_ack_ch0", b_ack, 4'b0001);
    b_req = 4'b0000;
    for (int i = 0; i < 50 && b_busy; i++) step();
    step();
    chk("t6_bytes", b_pushed, 14);
    chk("t6_queue_empty", qb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
